// File: rtl/imem_prog_loader.sv
// Boot-time instruction-memory loader: packs a byte stream MSB-first into 32-bit words and writes them from address 0.
// Optional feature macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte check (CHK state, chk_err).
module imem_prog_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              chk_err
);

  localparam logic [ADDR_W:0]   MAX_WORDS  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ZERO_WORDS = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   ONE_WORD   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ZERO_ADDR  = {ADDR_W{1'b0}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK   = 3'd4,
`endif
    DONE  = 3'd3
  } state_t;

  state_t          state;
  logic [1:0]      byte_cnt;
  logic [ADDR_W:0] word_cnt;
  logic [ADDR_W:0] word_total;
  logic [23:0]     asm_word;
  logic            accept;
  logic            last_word;

  // Clamping keeps the address from wrapping past the top of memory.
  function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] n);
    if (n > MAX_WORDS) begin
      return MAX_WORDS;
    end else begin
      return n;
    end
  endfunction

  assign accept    = byte_valid && byte_ready;
  assign last_word = ((word_cnt + ONE_WORD) == word_total);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_bad;
  logic       start_ok;

  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  assign csum_bad = (byte_in != csum);
  assign start_ok = start && ((state == IDLE) || (state == DONE));

  // Running checksum over data bytes and the sticky mismatch flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum    <= 8'd0;
      chk_err <= 1'b0;
    end else if (start_ok) begin
      csum    <= 8'd0;
      chk_err <= 1'b0;
    end else if ((state == RECV) && accept) begin
      csum <= xor_fold(csum, byte_in);
    end else if ((state == CHK) && accept) begin
      chk_err <= csum_bad;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

  // Load sequencer with registered handshake, write-port and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= ZERO_ADDR;
      imem_wdata <= 32'd0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      byte_cnt   <= 2'd0;
      word_cnt   <= ZERO_WORDS;
      word_total <= ZERO_WORDS;
      asm_word   <= 24'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            byte_cnt   <= 2'd0;
            word_cnt   <= ZERO_WORDS;
            word_total <= clamp_count(word_count);
            if (word_count == ZERO_WORDS) begin
              state      <= DONE;
              done       <= 1'b1;
              cpu_hold   <= 1'b0;
              busy       <= 1'b0;
              byte_ready <= 1'b0;
            end else begin
              state      <= RECV;
              done       <= 1'b0;
              cpu_hold   <= 1'b1;
              busy       <= 1'b1;
              byte_ready <= 1'b1;
            end
          end
        end
        RECV: begin
          if (accept) begin
            asm_word <= {asm_word[15:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state      <= WRITE;
              byte_ready <= 1'b0;
              imem_we    <= 1'b1;
              imem_addr  <= word_cnt[ADDR_W-1:0];
              imem_wdata <= {asm_word, byte_in};
            end
          end
        end
        WRITE: begin
          imem_we  <= 1'b0;
          word_cnt <= word_cnt + ONE_WORD;
          if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state      <= CHK;
            byte_ready <= 1'b1;
`else
            state      <= DONE;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            cpu_hold   <= 1'b0;
`endif
          end else begin
            state      <= RECV;
            byte_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (accept) begin
            state      <= DONE;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            cpu_hold   <= csum_bad;
          end
        end
`endif
        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          imem_we    <= 1'b0;
          cpu_hold   <= 1'b1;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule
